// File: rtl/can_tx_scheduler_if.sv
// Host/node-side bundle of the CAN transmit scheduler. The master side
// (host and node array) drives packets, ID writes, requests and retransmit
// flags. The slave side (the scheduler) returns the per-node packet and ID
// outputs plus the status counters.
interface can_tx_scheduler_if #(
  parameter int NODES     = 4,
  parameter int DATA_SIZE = 64,
  parameter int ID_SIZE   = 11,
  parameter int DEPTH     = 8
);
  logic                         pkt_valid;
  logic [DATA_SIZE-1:0]         pkt_data;
  logic                         pkt_ready;
  logic                         id_we;
  logic [$clog2(NODES)-1:0]     id_node;
  logic [ID_SIZE-1:0]           id_value;
  logic [NODES-1:0]             data_in_req;
  logic [NODES-1:0]             Retransmit;
  logic [NODES*DATA_SIZE-1:0]   In_packet;
  logic [NODES*ID_SIZE-1:0]     Tx_ID;
  logic [NODES*ID_SIZE-1:0]     Rx_ID;
  logic [NODES-1:0]             grant;
  logic [$clog2(DEPTH+1)-1:0]   fifo_count;
  logic [15:0]                  tx_count;
  logic [15:0]                  retry_count;

  modport master (
    output pkt_valid, pkt_data, id_we, id_node, id_value, data_in_req, Retransmit,
    input  pkt_ready, In_packet, Tx_ID, Rx_ID, grant, fifo_count, tx_count, retry_count
  );

  modport slave (
    input  pkt_valid, pkt_data, id_we, id_node, id_value, data_in_req, Retransmit,
    output pkt_ready, In_packet, Tx_ID, Rx_ID, grant, fifo_count, tx_count, retry_count
  );
endinterface

// File: rtl/can_tx_scheduler.sv
// CAN transmit scheduler. It buffers host packets in a FIFO and grants them
// round-robin to requesting nodes. On each grant it loads the winner's
// Tx_ID and its partner's (i^1) Rx_ID from the identifier table. Any node
// with a retransmit pending is forced to identifier 0.
module can_tx_scheduler #(
  parameter int NODES     = 4,
  parameter int DATA_SIZE = 64,
  parameter int ID_SIZE   = 11,
  parameter int DEPTH     = 8
) (
  input logic                clock,
  input logic                reset,
  can_tx_scheduler_if.slave  bus
);
  localparam int NB = $clog2(NODES);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, STARVED, WAIT_REL} state_t;

  state_t                          state, state_nx;
  logic [DATA_SIZE-1:0]            mem [DEPTH];
  logic [AW-1:0]                   wr_ptr, rd_ptr;
  logic [CW-1:0]                   count;
  logic                            push, fire, any_req, any_rt;
  logic [NB-1:0]                   ptr, sel, rr_idx;
  logic [NODES-1:0]                sel_oh, grant_q, rt_q;
  logic [NODES-1:0][ID_SIZE-1:0]   id_tab, tx_id, rx_id;
  logic [NODES-1:0][DATA_SIZE-1:0] in_pkt;
  logic [15:0]                     tx_cnt, retry_cnt, rise_cnt;

  assign bus.pkt_ready = (count != CW'(DEPTH));
  assign push          = bus.pkt_valid && bus.pkt_ready;
  assign any_req       = |bus.data_in_req;
  assign any_rt        = |bus.Retransmit;
  assign rise_cnt      = 16'($countones(bus.Retransmit & ~rt_q));
  assign sel_oh        = fire ? (NODES'(1) << sel) : '0;

  // Round-robin pick: the first requester after ptr. The descending scan
  // lets the nearest requester overwrite the farther ones.
  always_comb begin
    sel    = ptr;
    rr_idx = ptr;
    for (int k = NODES; k >= 1; k--) begin
      rr_idx = NB'((int'(ptr) + k) % NODES);
      if (bus.data_in_req[rr_idx]) sel = rr_idx;
    end
  end

  // Next-state and grant decision. A grant never coincides with a retransmit.
  always_comb begin
    state_nx = state;
    fire     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!any_rt && any_req) begin
          if (count == '0) state_nx = STARVED;
          else begin
            fire     = 1'b1;
            state_nx = WAIT_REL;
          end
        end
      end
      STARVED: begin
        if (!any_req) state_nx = IDLE;
        else if (!any_rt && count != '0) begin
          fire     = 1'b1;
          state_nx = WAIT_REL;
        end
      end
      WAIT_REL: if (!bus.data_in_req[ptr]) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Packet FIFO. A push and a pop in the same cycle leave the count unchanged.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.pkt_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (fire) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(fire);
    end
  end

  // Scheduler state, round-robin pointer, grant pulse and counters.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= NB'(NODES-1);
      grant_q   <= '0;
      tx_cnt    <= '0;
      retry_cnt <= '0;
      rt_q      <= '0;
    end else begin
      state     <= state_nx;
      grant_q   <= sel_oh;
      rt_q      <= bus.Retransmit;
      retry_cnt <= retry_cnt + rise_cnt;
      if (fire) begin
        ptr    <= sel;
        tx_cnt <= tx_cnt + 16'd1;
      end
    end
  end

  for (genvar j = 0; j < NODES; j++) begin : g_node
    localparam int            P = j ^ 1;
    localparam logic [NB-1:0] J = NB'(j);
    logic [ID_SIZE-1:0]   tab_r, tx_r, rx_r;
    logic [DATA_SIZE-1:0] pkt_r;

    // Per-node table entry and outputs. The retransmit clear is written last,
    // so it wins over a grant load in the same cycle.
    always_ff @(posedge clock) begin
      if (!reset) begin
        tab_r <= ID_SIZE'(j + 1);
        tx_r  <= '0;
        rx_r  <= '0;
        pkt_r <= '0;
      end else begin
        if (bus.id_we && bus.id_value != '0 && bus.id_node == J) tab_r <= bus.id_value;
        if (sel_oh[j]) begin
          pkt_r <= mem[rd_ptr];
          tx_r  <= tab_r;
        end
        if (sel_oh[P])         rx_r <= id_tab[P];
        if (bus.Retransmit[j]) tx_r <= '0;
        if (bus.Retransmit[P]) rx_r <= '0;
      end
    end

    assign id_tab[j] = tab_r;
    assign tx_id[j]  = tx_r;
    assign rx_id[j]  = rx_r;
    assign in_pkt[j] = pkt_r;
  end

  assign bus.In_packet   = in_pkt;
  assign bus.Tx_ID       = tx_id;
  assign bus.Rx_ID       = rx_id;
  assign bus.grant       = grant_q;
  assign bus.fifo_count  = count;
  assign bus.tx_count    = tx_cnt;
  assign bus.retry_count = retry_cnt;
endmodule

// File: tb/tb_can_tx_scheduler.sv
// Bench for can_tx_scheduler: directed scenarios followed by a random phase.
// The reference model works on a packet queue and a few ints. It runs on
// each rising edge and pushes every grant it predicts into a scoreboard.
// A monitor on the falling edge compares the DUT with the model and pops
// the scoreboard whenever the DUT shows a grant.
module tb_can_tx_scheduler;
  localparam int NODES     = 4;
  localparam int DATA_SIZE = 64;
  localparam int ID_SIZE   = 11;
  localparam int DEPTH     = 8;
  localparam int NB        = $clog2(NODES);

  typedef struct {
    int                   node;
    logic [DATA_SIZE-1:0] pkt;
    logic [ID_SIZE-1:0]   id;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  can_tx_scheduler_if #(.NODES(NODES), .DATA_SIZE(DATA_SIZE), .ID_SIZE(ID_SIZE), .DEPTH(DEPTH)) bus ();
  can_tx_scheduler #(.NODES(NODES), .DATA_SIZE(DATA_SIZE), .ID_SIZE(ID_SIZE), .DEPTH(DEPTH))
    dut (.clock(clock), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;
  bit auto_drop = 1'b1;

  // reference model state
  logic [DATA_SIZE-1:0] m_q[$];
  logic [ID_SIZE-1:0]   m_tab[NODES];
  logic [ID_SIZE-1:0]   m_tx[NODES];
  logic [ID_SIZE-1:0]   m_rx[NODES];
  logic [DATA_SIZE-1:0] m_pkt[NODES];
  logic [NODES-1:0]     m_grant, m_prev_rt;
  logic [15:0]          m_txc, m_retry;
  int                   m_ptr;
  bit                   m_wait;
  exp_t                 exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] tx(input int i);
    return 64'(bus.Tx_ID[i*ID_SIZE +: ID_SIZE]);
  endfunction
  function automatic logic [63:0] rx(input int i);
    return 64'(bus.Rx_ID[i*ID_SIZE +: ID_SIZE]);
  endfunction
  function automatic logic [63:0] inpkt(input int i);
    return bus.In_packet[i*DATA_SIZE +: DATA_SIZE];
  endfunction

  // Reference model: a grant happens when nobody is being waited on, some
  // node requests, no retransmit is pending and the queue holds a packet.
  initial forever begin
    @(posedge clock);
    begin : mdl
      logic [NODES-1:0] req, rt;
      int g, c;
      bit fire, do_push;
      exp_t e;
      req = bus.data_in_req;
      rt  = bus.Retransmit;
      m_grant = '0;
      if (!reset) begin
        m_q.delete();
        for (int i = 0; i < NODES; i++) begin
          m_tab[NB'(i)] = ID_SIZE'(i + 1);
          m_tx[NB'(i)]  = '0;
          m_rx[NB'(i)]  = '0;
          m_pkt[NB'(i)] = '0;
        end
        m_ptr = NODES - 1; m_wait = 1'b0; m_txc = '0; m_retry = '0; m_prev_rt = '0;
      end else begin
        do_push = bus.pkt_valid && (m_q.size() < DEPTH);
        fire = 1'b0; g = 0;
        if (m_wait) begin
          if (!req[NB'(m_ptr)]) m_wait = 1'b0;
        end else if (req != '0 && rt == '0 && m_q.size() > 0) begin
          for (int k = 1; k <= NODES; k++) begin
            c = (m_ptr + k) % NODES;
            if (!fire && req[NB'(c)]) begin fire = 1'b1; g = c; end
          end
        end
        if (fire) begin
          m_pkt[NB'(g)]     = m_q.pop_front();
          m_tx[NB'(g)]      = m_tab[NB'(g)];
          m_rx[NB'(g ^ 1)]  = m_tab[NB'(g)];
          m_grant = NODES'(1) << g;
          m_ptr = g; m_wait = 1'b1; m_txc = m_txc + 16'd1;
          e.node = g; e.pkt = m_pkt[NB'(g)]; e.id = m_tab[NB'(g)];
          exp_q.push_back(e);
        end
        for (int i = 0; i < NODES; i++)
          if (rt[NB'(i)]) begin m_tx[NB'(i)] = '0; m_rx[NB'(i ^ 1)] = '0; end
        m_retry = m_retry + 16'($countones(rt & ~m_prev_rt));
        m_prev_rt = rt;
        if (bus.id_we && bus.id_value != '0) m_tab[bus.id_node] = bus.id_value;
        if (do_push) m_q.push_back(bus.pkt_data);
      end
      started = 1'b1;
    end
  end

  // Monitor: per-cycle comparison against the model and scoreboard pop on grant.
  initial forever begin
    @(negedge clock);
    if (started) begin : mon
      exp_t e;
      chk("pkt_ready",   64'(bus.pkt_ready),   64'(m_q.size() < DEPTH));
      chk("fifo_count",  64'(bus.fifo_count),  64'(m_q.size()));
      chk("grant",       64'(bus.grant),       64'(m_grant));
      chk("tx_count",    64'(bus.tx_count),    64'(m_txc));
      chk("retry_count", 64'(bus.retry_count), 64'(m_retry));
      for (int i = 0; i < NODES; i++) begin
        chk($sformatf("tx_id[%0d]", i), tx(i), 64'(m_tx[NB'(i)]));
        chk($sformatf("rx_id[%0d]", i), rx(i), 64'(m_rx[NB'(i)]));
        chk($sformatf("in_packet[%0d]", i), inpkt(i), m_pkt[NB'(i)]);
      end
      if (bus.grant != '0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected grant=%b expected=none", bus.grant);
        end else begin
          e = exp_q.pop_front();
          chk("sb_node", 64'(bus.grant), 64'(NODES'(1) << e.node));
          chk("sb_pkt", inpkt(e.node), e.pkt);
          chk("sb_tx_id", tx(e.node), 64'(e.id));
          chk("sb_rx_id", rx(e.node ^ 1), 64'(e.id));
        end
      end
      if (exp_q.size() != 0) begin
        checks++; errors++;
        $display("FAIL sb_missing grant=none expected_node=%0d", exp_q[0].node);
        exp_q.delete();
      end
    end
  end

  // One clock: inputs are sampled at the rising edge; this returns at the next
  // falling edge and applies the host/node reactions (accepted packet,
  // granted request dropped).
  task automatic tick();
    logic rdy;
    rdy = bus.pkt_ready;
    @(posedge clock);
    @(negedge clock);
    if (bus.pkt_valid && rdy === 1'b1 && reset) bus.pkt_valid = 1'b0;
    if (auto_drop) bus.data_in_req = bus.data_in_req & ~bus.grant;
  endtask

  task automatic push(input logic [DATA_SIZE-1:0] d);
    bus.pkt_valid = 1'b1;
    bus.pkt_data  = d;
    for (int n = 0; n < 40 && bus.pkt_valid; n++) tick();
    checks++;
    if (bus.pkt_valid) begin
      errors++;
      $display("FAIL push_timeout data=%0h accepted=0 required=1", d);
      bus.pkt_valid = 1'b0;
    end
  endtask

  task automatic wait_grant(input int bound, output int node);
    node = -1;
    for (int n = 0; n < bound && node < 0; n++) begin
      tick();
      for (int i = 0; i < NODES; i++) if (bus.grant[NB'(i)]) node = i;
    end
    checks++;
    if (node < 0) begin
      errors++;
      $display("FAIL grant_timeout got=none required=grant within %0d cycles", bound);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog sim_time=%0t required=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int node;
    int order[3];
    bus.pkt_valid = 1'b0; bus.pkt_data = '0; bus.id_we = 1'b0; bus.id_node = '0;
    bus.id_value = '0; bus.data_in_req = '0; bus.Retransmit = '0;

    // reset values
    reset = 1'b0;
    tick(); tick();
    chk("rst_pkt_ready", 64'(bus.pkt_ready), 64'd1);
    chk("rst_fifo_count", 64'(bus.fifo_count), 64'd0);
    chk("rst_grant", 64'(bus.grant), 64'd0);
    chk("rst_tx_id", 64'(bus.Tx_ID), 64'd0);
    reset = 1'b1;
    bus.id_we = 1'b1; bus.id_node = NB'(2); bus.id_value = ID_SIZE'('h155);
    tick();
    bus.id_we = 1'b0;

    // round robin over requests 1011
    push(64'hA); push(64'hB); push(64'hC);
    bus.data_in_req = 4'b1011;
    for (int n = 0; n < 3; n++) begin
      wait_grant(10, node);
      order[n] = node;
      if (node >= 0) chk("rr_pkt", inpkt(node), 64'hA + 64'(n));
    end
    chk("rr_order0", 64'(order[0]), 64'd0);
    chk("rr_order1", 64'(order[1]), 64'd1);
    chk("rr_order2", 64'(order[2]), 64'd3);
    chk("rr_rx1", rx(1), 64'd1);
    chk("rr_rx0", rx(0), 64'd2);
    chk("rr_rx2", rx(2), 64'd4);
    chk("rr_tx_count", 64'(bus.tx_count), 64'd3);

    // starvation, then a grant to node 2 showing the written ID
    bus.data_in_req = 4'b0100;
    tick(); tick(); tick();
    chk("starved_no_grant", 64'(bus.grant), 64'd0);
    bus.pkt_valid = 1'b1; bus.pkt_data = 64'hDEAD;
    tick();
    tick();
    chk("starved_grant", 64'(bus.grant), 64'b0100);
    chk("starved_pkt", inpkt(2), 64'hDEAD);
    chk("starved_tx2", tx(2), 64'h155);
    chk("starved_rx3", rx(3), 64'h155);
    tick();

    // retransmit blocks the grant
    push(64'h1111); push(64'h2222);
    bus.Retransmit = 4'b0010; bus.data_in_req = 4'b0001;
    tick();
    chk("rt_tx1", tx(1), 64'd0);
    chk("rt_rx0", rx(0), 64'd0);
    chk("rt_no_grant", 64'(bus.grant), 64'd0);
    chk("rt_retry_count", 64'(bus.retry_count), 64'd1);
    tick();
    chk("rt_no_grant2", 64'(bus.grant), 64'd0);
    bus.Retransmit = '0;
    tick();
    chk("rt_release_grant", 64'(bus.grant), 64'b0001);
    tick();

    // FIFO full, held packet, one grant frees a slot
    for (int n = 0; n < 20 && bus.fifo_count != 4'(DEPTH); n++) push(64'h3000 + 64'(n));
    chk("full_ready", 64'(bus.pkt_ready), 64'd0);
    chk("full_count", 64'(bus.fifo_count), 64'd8);
    bus.pkt_valid = 1'b1; bus.pkt_data = 64'h9999;
    tick(); tick();
    chk("full_held", 64'(bus.pkt_valid), 64'd1);
    chk("full_held_count", 64'(bus.fifo_count), 64'd8);
    bus.data_in_req = 4'b1000;
    tick();
    chk("full_grant", 64'(bus.grant), 64'b1000);
    chk("full_ready_after_pop", 64'(bus.pkt_ready), 64'd1);
    tick();
    chk("full_accepted", 64'(bus.pkt_valid), 64'd0);
    chk("full_count_again", 64'(bus.fifo_count), 64'd8);

    // reset while waiting for release
    auto_drop = 1'b0;
    bus.data_in_req = 4'b0010;
    wait_grant(5, node);
    reset = 1'b0;
    tick();
    chk("mrst_grant", 64'(bus.grant), 64'd0);
    chk("mrst_count", 64'(bus.fifo_count), 64'd0);
    chk("mrst_ready", 64'(bus.pkt_ready), 64'd1);
    reset = 1'b1; bus.data_in_req = '0; auto_drop = 1'b1;
    tick();
    push(64'h77);
    bus.data_in_req = 4'b0100;
    wait_grant(10, node);
    chk("mrst_tab_tx2", tx(2), 64'd3);
    chk("mrst_tab_rx3", rx(3), 64'd3);
    tick();

    // random traffic
    for (int c = 0; c < 2500; c++) begin
      if (!bus.pkt_valid && $urandom_range(0, 1) == 1) begin
        bus.pkt_valid = 1'b1;
        bus.pkt_data  = {$urandom, $urandom};
      end
      bus.data_in_req = bus.data_in_req | NODES'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 9) == 0)
        bus.Retransmit = ($urandom_range(0, 2) == 0) ? NODES'($urandom) : '0;
      bus.id_we    = ($urandom_range(0, 7) == 0);
      bus.id_node  = NB'($urandom);
      bus.id_value = ($urandom_range(0, 3) == 0) ? '0 : ID_SIZE'($urandom);
      reset        = ($urandom_range(0, 399) != 0);
      tick();
    end
    reset = 1'b1; bus.Retransmit = '0; bus.id_we = 1'b0; bus.data_in_req = '0;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
